// File: rtl/window_conv_pkg.sv
// Shared definitions for the 3x3 window convolution datapath.
// Optional build macro: WINDOW_CONV_ABS_EN selects edge-magnitude output,
// where a negative result is replaced by its absolute value instead of 0.
package window_conv_pkg;

  localparam int PIX_W   = 8;
  localparam int ACC_W   = 20;
  localparam int SHIFT_W = 4;
  localparam int NTAP    = 9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Map a shifted accumulator value onto the 8-bit pixel range.
  function automatic logic [PIX_W-1:0] saturate(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] m;
`ifdef WINDOW_CONV_ABS_EN
    m = (v < 0) ? -v : v;
`else
    m = (v < 0) ? '0 : v;
`endif
    if (m > $signed(ACC_W'(255))) return {PIX_W{1'b1}};
    return m[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/window_conv_3x3_mac9.sv
// Nine-tap multiply/accumulate: registered products, then registered sum.
// Pixels are unsigned, coefficients signed; the sum is 20-bit signed.
module conv_mac9
  import window_conv_pkg::*;
#(
  parameter int COEF_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     vld_p0,
  input  logic [NTAP*PIX_W-1:0]    pix_p0,
  input  logic [NTAP*COEF_W-1:0]   coef,
  output logic                     vld_p2,
  output logic [ACC_W-1:0]         sum_p2
);

  localparam int PROD_W = PIX_W + COEF_W;

  logic signed [PROD_W:0]   prod_c  [NTAP];
  logic signed [PROD_W-1:0] prod_p1 [NTAP];
  logic signed [ACC_W-1:0]  sum_c;
  logic                     vld_p1;

  // Full-width signed products; the zero-extended pixel keeps it non-negative.
  always_comb begin
    for (int k = 0; k < NTAP; k++) begin
      prod_c[k] = $signed({{(COEF_W+1){1'b0}}, pix_p0[k*PIX_W +: PIX_W]}) *
                  $signed({{(PIX_W+1){coef[k*COEF_W+COEF_W-1]}}, coef[k*COEF_W +: COEF_W]});
    end
  end

  // ---- stage 1: product registers ----
  always_ff @(posedge clk) begin
    for (int k = 0; k < NTAP; k++) begin
      prod_p1[k] <= prod_c[k][PROD_W-1:0];
    end
  end

  // Stage 1 valid, cleared by reset so in-flight windows are dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= vld_p0;
  end

  // Sign-extended adder tree over the nine products.
  always_comb begin
    sum_c = '0;
    for (int k = 0; k < NTAP; k++) begin
      sum_c = sum_c + ACC_W'(prod_p1[k]);
    end
  end

  // ---- stage 2: accumulator register ----
  always_ff @(posedge clk) begin
    sum_p2 <= sum_c;
  end

  // Stage 2 valid.
  always_ff @(posedge clk) begin
    if (!rst_n) vld_p2 <= 1'b0;
    else        vld_p2 <= vld_p1;
  end

endmodule

// File: rtl/window_conv_3x3.sv
// 3x3 window convolution: frame FSM, window counter, coefficient bank and
// the shift/clamp output stage around the conv_mac9 product/sum pipeline.
// Optional build macro: WINDOW_CONV_ABS_EN (edge magnitude output).
module window_conv_3x3
  import window_conv_pkg::*;
#(
  parameter int COEF_W    = 8,
  parameter int FRAME_WIN = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        pixel1,
  input  logic [7:0]        pixel2,
  input  logic [7:0]        pixel3,
  input  logic [7:0]        pixel4,
  input  logic [7:0]        pixel5,
  input  logic [7:0]        pixel6,
  input  logic [7:0]        pixel7,
  input  logic [7:0]        pixel8,
  input  logic [7:0]        pixel9,
  input  logic              coef_wr,
  input  logic [3:0]        coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  output logic              out_valid,
  output logic [7:0]        pixel_out,
  output logic              busy,
  output logic              frame_done,
  output logic              overrun
);

  state_t                    state, state_nx;
  logic [12:0]               win_cnt;
  logic [1:0]                drain_cnt;
  logic signed [COEF_W-1:0]  coef [NTAP];
  logic [SHIFT_W-1:0]        shift;
  logic [NTAP*COEF_W-1:0]    coef_flat;
  logic [NTAP*PIX_W-1:0]     pix_p0;
  logic                      vld_p0;
  logic                      start_acc;
  logic                      last_win;
  logic                      coef_en;
  logic                      vld_p2;
  logic [ACC_W-1:0]          sum_p2;
  logic signed [ACC_W-1:0]   shifted;

  assign vld_p0    = in_valid && (state == ST_RUN);
  assign start_acc = start && (state == ST_IDLE);
  assign last_win  = vld_p0 && (win_cnt == 13'(FRAME_WIN - 1));
  assign coef_en   = coef_wr && ((state == ST_IDLE) || (state == ST_DONE)) &&
                     (coef_addr <= 4'd9);
  assign busy       = (state == ST_RUN) || (state == ST_DRAIN);
  assign frame_done = (state == ST_DONE);
  assign pix_p0 = {pixel9, pixel8, pixel7, pixel6, pixel5,
                   pixel4, pixel3, pixel2, pixel1};

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic: DRAIN covers the pipeline depth so DONE follows the last output.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (start)            state_nx = ST_RUN;
      ST_RUN:   if (last_win)         state_nx = ST_DRAIN;
      ST_DRAIN: if (drain_cnt == 2'd2) state_nx = ST_DONE;
      ST_DONE:                        state_nx = ST_IDLE;
      default:                        state_nx = ST_IDLE;
    endcase
  end

  // Cycles spent in DRAIN.
  always_ff @(posedge clk) begin
    if (!rst_n)                 drain_cnt <= '0;
    else if (state == ST_DRAIN) drain_cnt <= drain_cnt + 2'd1;
    else                        drain_cnt <= '0;
  end

  // Accepted-window counter for the current frame.
  always_ff @(posedge clk) begin
    if (!rst_n)         win_cnt <= '0;
    else if (start_acc) win_cnt <= '0;
    else if (vld_p0)    win_cnt <= win_cnt + 13'd1;
  end

  // Sticky flag for windows offered while the pipeline drains.
  always_ff @(posedge clk) begin
    if (!rst_n)                                overrun <= 1'b0;
    else if (start_acc)                        overrun <= 1'b0;
    else if ((state == ST_DRAIN) && in_valid)  overrun <= 1'b1;
  end

  // Coefficient bank and shift; reset loads the identity kernel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NTAP; k++) coef[k] <= (k == 4) ? COEF_W'(1) : '0;
      shift <= '0;
    end else if (coef_en) begin
      if (coef_addr == 4'd9) shift <= coef_data[SHIFT_W-1:0];
      for (int k = 0; k < NTAP; k++) begin
        if (coef_addr == 4'(k)) coef[k] <= coef_data;
      end
    end
  end

  // Flatten the coefficient bank for the MAC port.
  always_comb begin
    coef_flat = '0;
    for (int k = 0; k < NTAP; k++) coef_flat[k*COEF_W +: COEF_W] = coef[k];
  end

  conv_mac9 #(
    .COEF_W (COEF_W)
  ) u_mac9 (
    .clk    (clk),
    .rst_n  (rst_n),
    .vld_p0 (vld_p0),
    .pix_p0 (pix_p0),
    .coef   (coef_flat),
    .vld_p2 (vld_p2),
    .sum_p2 (sum_p2)
  );

  assign shifted = $signed(sum_p2) >>> shift;

  // ---- stage 3: shift, clamp and output register ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      pixel_out <= '0;
    end else begin
      out_valid <= vld_p2;
      pixel_out <= vld_p2 ? saturate(shifted) : '0;
    end
  end

endmodule
